// File: rtl/periph_pkg.sv
// periph_pkg: shared register offsets and bit positions for the peripheral register windows
package periph_pkg;
  localparam logic [3:0] RXF_DATA = 4'h0;
  localparam logic [3:0] RXF_STATUS = 4'h2;
  localparam logic [3:0] RXF_LINES = 4'h4;
  localparam logic [3:0] RXF_CTRL = 4'h6;
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVERFLOW = 2;
  localparam int ST_COUNT = 8;
  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR_OVF = 1;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: 2^DEPTH_LOG2 x 8 storage, synchronous write (clk, we, waddr, wdata), asynchronous read (raddr -> rdata)
module sync_fifo_mem #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [7:0]            rdata
);
  logic [7:0] mem [1<<DEPTH_LOG2];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/peripheral_rx_fifo.sv
// peripheral_rx_fifo: UART rx byte FIFO with J1 register window (rx_data/rx_avail in; cs/addr/rd/wr/d_in -> d_out; rx_irq), optional line counter via RXFIFO_LINE_CNT_EN
module peripheral_rx_fifo
  import periph_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  output logic        rx_irq
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1 << DEPTH_LOG2);
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx, lines;
  logic [7:0] head;
  logic overflow, not_empty, full, pop, push, drop, ctrl_wr, flush, clr_ovf, irq_nx, unused_bits;
  logic [15:0] status;
  assign not_empty = count != '0;
  assign full = count == DEPTH;
  assign pop = cs & rd & (addr == RXF_DATA) & not_empty;
  assign ctrl_wr = cs & wr & (addr == RXF_CTRL);
  assign flush = ctrl_wr & d_in[CTRL_FLUSH];
  assign clr_ovf = ctrl_wr & d_in[CTRL_CLR_OVF];
  assign push = rx_avail & (~full | pop) & ~flush;
  assign drop = rx_avail & full & ~pop & ~flush;
  assign count_nx = flush ? '0 : count + CW'(push) - CW'(pop);
  assign unused_bits = ^d_in[15:2];
  sync_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(rx_data),
    .raddr(rd_ptr),
    .rdata(head)
  );
`ifdef RXFIFO_LINE_CNT_EN
  logic [CW-1:0] lines_nx;
  assign lines_nx = flush ? '0 : lines + CW'(push & (rx_data == 8'h0A)) - CW'(pop & (head == 8'h0A));
  assign irq_nx = lines_nx != '0;
  always_ff @(posedge clk)
    if (rst) lines <= '0;
    else lines <= lines_nx;
`else
  assign lines = '0;
  assign irq_nx = count_nx != '0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      rx_irq <= 1'b0;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + DEPTH_LOG2'(push);
      rd_ptr <= flush ? '0 : rd_ptr + DEPTH_LOG2'(pop);
      count <= count_nx;
      overflow <= drop | (overflow & ~clr_ovf);
      rx_irq <= irq_nx;
    end
  always_comb begin
    status = (16'(count) << ST_COUNT) | (16'(overflow) << ST_OVERFLOW) | (16'(full) << ST_FULL) | (16'(not_empty) << ST_NOT_EMPTY);
    d_out = !cs ? 16'h0000 :
            addr == RXF_DATA ? (not_empty ? {8'h00, head} : 16'h0000) :
            addr == RXF_STATUS ? status :
            addr == RXF_LINES ? 16'(lines) : 16'h0000;
  end
endmodule
